// File: rtl/simon_key_sched_ctrl.sv
// simon_key_sched_ctrl: streams Simon 96/96 round keys k_0..k_{T-1} from a latched master key
//   clk, rst_n       : clock, asynchronous active-low reset
//   start, key       : latch key (k_0 = key[N-1:0], k_1 = key[2N-1:N]) and begin, sampled in IDLE
//   abort            : cancel a run in progress, no done pulse
//   rk_ready         : consumer accepts rk this cycle
//   rk_valid, rk     : current round key k_idx
//   rk_idx, rk_last  : round index and last-key flag
//   busy, done       : run in progress; one-cycle pulse after the last key is accepted
module simon_key_sched_ctrl #(
    parameter int N = 48,
    parameter int M = 2,
    parameter int T = 52
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N*M-1:0] key,
    input  logic           abort,
    input  logic           rk_ready,
    output logic           rk_valid,
    output logic [N-1:0]   rk,
    output logic [6:0]     rk_idx,
    output logic           rk_last,
    output logic           busy,
    output logic           done
);
    // Bit 0 of the z2 sequence is the leftmost character.
    localparam logic [0:61] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    typedef enum logic {IDLE, RUN} state_t;
    state_t       state_q, state_d;
    logic [N-1:0] kr0_q, kr0_d, kr1_q, kr1_d, t3, t, f;
    logic [6:0]   idx_q, idx_d;
    logic [5:0]   zidx_q, zidx_d;
    logic         done_q, done_d;
    logic         run, last;
    assign run  = state_q == RUN;
    assign last = idx_q == 7'(T - 1);
    // k_{i+2} = ~k_i ^ t ^ ROR1(t) ^ z2[j] ^ 3, with t = ROR3(k_{i+1}); the ~ and ^3 fold into one mask.
    assign t3 = {kr1_q[2:0], kr1_q[N-1:3]};
    assign t  = t3 ^ {t3[0], t3[N-1:1]};
    assign f  = kr0_q ^ t ^ {{(N-2){1'b1}}, 2'b00} ^ {{(N-1){1'b0}}, Z2[zidx_q]};
    always_comb begin
        state_d = state_q;
        kr0_d   = kr0_q;
        kr1_d   = kr1_q;
        idx_d   = idx_q;
        zidx_d  = zidx_q;
        done_d  = 1'b0;
        if (!run) begin
            if (start) begin
                state_d = RUN;
                kr0_d   = key[N-1:0];
                kr1_d   = key[2*N-1:N];
                idx_d   = '0;
                zidx_d  = '0;
            end
        end else if (abort || (rk_ready && last)) begin
            // Clearing on every return to IDLE keeps rk and rk_idx at zero while idle.
            state_d = IDLE;
            kr0_d   = '0;
            kr1_d   = '0;
            idx_d   = '0;
            done_d  = !abort;
        end else if (rk_ready) begin
            kr0_d  = kr1_q;
            kr1_d  = f;
            idx_d  = idx_q + 7'd1;
            zidx_d = (zidx_q == 6'd61) ? 6'd0 : zidx_q + 6'd1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            kr0_q   <= '0;
            kr1_q   <= '0;
            idx_q   <= '0;
            zidx_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kr0_q   <= kr0_d;
            kr1_q   <= kr1_d;
            idx_q   <= idx_d;
            zidx_q  <= zidx_d;
            done_q  <= done_d;
        end
    end
    assign rk_valid = run;
    assign rk       = kr0_q;
    assign rk_idx   = idx_q;
    assign rk_last  = run && last;
    assign busy     = run;
    assign done     = done_q;
endmodule

// File: tb/tb_simon_key_sched_ctrl.sv
// tb_simon_key_sched_ctrl: directed self-checking bench for simon_key_sched_ctrl
module tb_simon_key_sched_ctrl;
    localparam logic [95:0] KP = 96'h0d0c0b0a0908_050403020100;
    localparam logic [95:0] KB = 96'h123456789abc_fedcba987654;
    logic        clk = 0, rst_n = 0, start = 0, abort = 0, rk_ready = 0, start2 = 0;
    logic        no_abort = 0, ready2 = 1;
    logic [95:0] key = '0;
    logic        rk_valid, rk_last, busy, done, rk_valid2, rk_last2, busy2, done2;
    logic [47:0] rk, rk2;
    logic [6:0]  rk_idx, rk_idx2;
    logic [61:0] z = 62'b10101111011100000011010010011000101000010001111110010110110011;
    logic [47:0] ks [0:127];
    logic [47:0] got [0:51];
    int          n_chk = 0, n_fail = 0;
    wire  [58:0] obs  = {rk_valid, rk, rk_idx, rk_last, busy, done};
    wire  [58:0] obs2 = {rk_valid2, rk2, rk_idx2, rk_last2, busy2, done2};
    wire  [58:0] done_pat = {1'b0, 48'd0, 7'd0, 1'b0, 1'b0, 1'b1};

    simon_key_sched_ctrl #(.N(48), .M(2), .T(52)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .abort(abort), .rk_ready(rk_ready),
        .rk_valid(rk_valid), .rk(rk), .rk_idx(rk_idx), .rk_last(rk_last), .busy(busy), .done(done)
    );
    simon_key_sched_ctrl #(.N(48), .M(2), .T(100)) dut100 (
        .clk(clk), .rst_n(rst_n), .start(start2), .key(key), .abort(no_abort), .rk_ready(ready2),
        .rk_valid(rk_valid2), .rk(rk2), .rk_idx(rk_idx2), .rk_last(rk_last2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] ror(input logic [47:0] x, input int r);
        return (x >> r) | (x << (48 - r));
    endfunction
    function automatic logic [47:0] rol(input logic [47:0] x, input int r);
        return (x << r) | (x >> (48 - r));
    endfunction

    // Reference key expansion straight from the cipher definition, 100 keys.
    task automatic build(input logic [95:0] k);
        logic [47:0] t;
        ks[0] = k[47:0];
        ks[1] = k[95:48];
        for (int i = 0; i < 98; i++) begin
            t = ror(ks[i+1], 3);
            ks[i+2] = ~ks[i] ^ t ^ ror(t, 1) ^ {47'd0, z[61 - (i % 62)]} ^ 48'd3;
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic [95:0] k);
        key = k;
        start = 1;
        step;
        start = 0;
    endtask

    task automatic test_reset;
        #3;
        n_chk++;
        if ({obs, obs2} !== '0) begin
            n_fail++;
            $display("FAIL reset_held: got %h / %h, want 0", obs, obs2);
        end
        step;
        rst_n = 1;
        step;
        n_chk++;
        if ({obs, obs2} !== '0) begin
            n_fail++;
            $display("FAIL reset_released: got %h / %h, want 0", obs, obs2);
        end
    endtask

    task automatic test_paper_vector;
        logic [47:0] x, y, tmp;
        build(KP);
        rk_ready = 1;
        begin_run(KP);
        for (int i = 0; i < 52; i++) begin
            n_chk++;
            if (obs !== {1'b1, ks[i], 7'(i), i == 51, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL paper_key[%0d]: got %h, want %h", i, obs, {1'b1, ks[i], 7'(i), i == 51, 1'b1, 1'b0});
            end
            got[i] = rk;
            step;
        end
        n_chk++;
        if (obs !== done_pat) begin
            n_fail++;
            $display("FAIL paper_done: got %h, want %h", obs, done_pat);
        end
        step;
        n_chk++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL paper_done_once: got %h, want 0", obs);
        end
        n_chk++;
        if (got[0] !== 48'h050403020100 || got[1] !== 48'h0d0c0b0a0908) begin
            n_fail++;
            $display("FAIL paper_k0k1: got %h %h, want 050403020100 0d0c0b0a0908", got[0], got[1]);
        end
        // The captured keys must encrypt the published plaintext to the published ciphertext.
        x = 48'h2072616c6c69;
        y = 48'h702065687420;
        for (int i = 0; i < 52; i++) begin
            tmp = x;
            x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ got[i];
            y = tmp;
        end
        n_chk++;
        if ({x, y} !== 96'h602807a462b469063d8ff082) begin
            n_fail++;
            $display("FAIL paper_cipher: got %h, want 602807a462b469063d8ff082", {x, y});
        end
    endtask

    task automatic test_backpressure;
        int acc = 0, cyc = 0;
        build(KP);
        rk_ready = 0;
        begin_run(KP);
        while (acc < 52 && cyc < 600) begin
            n_chk++;
            if (obs !== {1'b1, ks[acc], 7'(acc), acc == 51, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_key[%0d] cyc %0d: got %h, want %h", acc, cyc, obs, {1'b1, ks[acc], 7'(acc), acc == 51, 1'b1, 1'b0});
            end
            rk_ready = 1'($urandom_range(0, 1));
            step;
            if (rk_ready) acc++;
            cyc++;
        end
        n_chk++;
        if (acc < 52) begin
            n_fail++;
            $display("FAIL bp_timeout: accepted %0d, want 52", acc);
        end else if (obs !== done_pat) begin
            n_fail++;
            $display("FAIL bp_done: got %h, want %h", obs, done_pat);
        end
        rk_ready = 1;
        step;
    endtask

    task automatic test_abort;
        build(KP);
        rk_ready = 1;
        begin_run(KP);
        for (int i = 0; i < 11; i++) begin
            n_chk++;
            if (obs !== {1'b1, ks[i], 7'(i), 1'b0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL abort_pre[%0d]: got %h, want %h", i, obs, {1'b1, ks[i], 7'(i), 1'b0, 1'b1, 1'b0});
            end
            if (i < 10) step;
        end
        abort = 1;
        step;
        abort = 0;
        n_chk++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL abort_idle: got %h, want 0", obs);
        end
        step;
        n_chk++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %h, want 0", obs);
        end
        begin_run(KB);
        n_chk++;
        if (obs !== {1'b1, 48'hfedcba987654, 7'd0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_restart: got %h, want k_0 fedcba987654", obs);
        end
        abort = 1;
        step;
        abort = 0;
    endtask

    task automatic test_async_reset;
        build(KP);
        rk_ready = 1;
        begin_run(KP);
        repeat (20) step;
        n_chk++;
        if (obs !== {1'b1, ks[20], 7'd20, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL arst_idx20: got %h, want %h", obs, {1'b1, ks[20], 7'd20, 1'b0, 1'b1, 1'b0});
        end
        #2 rst_n = 0;
        #1;
        n_chk++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL arst_immediate: got %h, want 0", obs);
        end
        step;
        step;
        #2 rst_n = 1;
        step;
        n_chk++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL arst_released: got %h, want 0", obs);
        end
        begin_run('0);
        n_chk++;
        if (obs !== {1'b1, 48'd0, 7'd0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL arst_zero_k0: got %h", obs);
        end
        step;
        n_chk++;
        if (obs !== {1'b1, 48'd0, 7'd1, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL arst_zero_k1: got %h", obs);
        end
        step;
        n_chk++;
        if (obs !== {1'b1, 48'hFFFF_FFFF_FFFD, 7'd2, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL arst_zero_k2: got %h, want rk FFFFFFFFFFFD idx 2", obs);
        end
        abort = 1;
        step;
        abort = 0;
    endtask

    task automatic test_start_handling;
        build(KP);
        rk_ready = 1;
        begin_run(KP);
        for (int i = 0; i < 52; i++) begin
            n_chk++;
            if (obs !== {1'b1, ks[i], 7'(i), i == 51, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL start_ignored[%0d]: got %h, want %h", i, obs, {1'b1, ks[i], 7'(i), i == 51, 1'b1, 1'b0});
            end
            start = (i == 5);
            if (i == 5) key = KB;
            step;
        end
        n_chk++;
        if (obs !== done_pat) begin
            n_fail++;
            $display("FAIL start_done: got %h, want %h", obs, done_pat);
        end
        begin_run(KB);
        n_chk++;
        if (obs !== {1'b1, 48'hfedcba987654, 7'd0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL start_in_done: got %h, want k_0 fedcba987654 idx 0", obs);
        end
        abort = 1;
        step;
        abort = 0;
        n_chk++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL start_abort_idle: got %h, want 0", obs);
        end
    endtask

    task automatic test_wrap;
        build(KP);
        key = KP;
        start2 = 1;
        step;
        start2 = 0;
        for (int i = 0; i < 100; i++) begin
            n_chk++;
            if (obs2 !== {1'b1, ks[i], 7'(i), i == 99, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL wrap_key[%0d]: got %h, want %h", i, obs2, {1'b1, ks[i], 7'(i), i == 99, 1'b1, 1'b0});
            end
            step;
        end
        n_chk++;
        if (obs2 !== done_pat) begin
            n_fail++;
            $display("FAIL wrap_done: got %h, want %h", obs2, done_pat);
        end
    endtask

    initial begin
        test_reset;
        test_paper_vector;
        test_backpressure;
        test_abort;
        test_async_reset;
        test_start_handling;
        test_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/simon_key_sched_ctrl.md
# simon_key_sched_ctrl

Sequential round-key controller for the Simon 96/96 cipher (N=48, M=2, T=52). It latches a 96-bit master key on a start strobe and then streams one round key per accepted handshake, k_0 through k_{T-1}. It sits between the key register and the round-function datapath, replacing random-access per-round key evaluation with a two-word shift register and a z-sequence counter.

## Interface
- N, default 48: word width in bits.
- M, default 2: key words. Only M=2 is supported.
- T, default 52: number of round keys emitted. Legal range 1..127.
- clk  in  1: rising-edge clock.
- rst_n  in  1: asynchronous active-low reset.
- start  in  1: load key and begin. Sampled only in IDLE.
- key  in  N*M: master key. Word k_0 is key[N-1:0]; word k_1 is key[2N-1:N].
- abort  in  1: synchronous cancel. Effective only in RUN.
- rk_ready  in  1: consumer accepts rk this cycle.
- rk_valid  out  1: rk is valid.
- rk  out  N: current round key k_idx.
- rk_idx  out  7: round index of rk.
- rk_last  out  1: asserted with rk_valid when rk_idx == T-1.
- busy  out  1: high in RUN.
- done  out  1: one-cycle pulse after the last key is accepted.

## Operation
- FSM states: IDLE and RUN. Registers:
  - kr0, kr1: N bits each.
  - idx: 7 bits.
  - zidx: 6 bits, counts 0..61.
  - done_r: 1 bit.
- Transitions out of IDLE:
  - IDLE & start: kr0←key[N-1:0], kr1←key[2N-1:N], idx←0, zidx←0, go to RUN.
  - start while RUN is ignored.
- RUN outputs: rk_valid=1, rk=kr0, rk_idx=idx, rk_last=(idx==T-1), busy=1.
- Handshake is rk_valid & rk_ready. Action on handshake:
  - If idx==T-1: go to IDLE and set done_r for one cycle.
  - Otherwise: kr0←kr1, kr1←f(kr0,kr1,zidx), idx←idx+1. zidx←(zidx==61)?0:zidx+1.
- Expansion function f(a,b,j):
  - t = ROR3(b)
  - t = t ^ ROR1(t)
  - f = ~a ^ t ^ z2[j] ^ 3
  - z2[j] is zero-extended. Equivalently f = a ^ t ^ 0xFFFF_FFFF_FFFC ^ z2[j].
  - z2 = 10101111011100000011010010011000101000010001111110010110110011. Bit j=0 is the leftmost character.
  - All arithmetic is bitwise, mod 2^N. RORr is a right rotate of N bits.
- Without a handshake (rk_ready=0) all registers hold, and rk and rk_idx stay stable.
- abort in RUN: go to IDLE next cycle, no done pulse, kr0, kr1 and idx cleared. abort has priority over a simultaneous handshake.
- IDLE outputs: rk_valid=0, rk_last=0, busy=0. rk and rk_idx read 0, because kr0 and idx are cleared on every return to IDLE.
- Reset (any time, including mid-run): state=IDLE; kr0, kr1, idx, zidx, done_r = 0. All outputs read 0 while rst_n=0 and after its release.

## Timing
- All outputs are registered or decoded from registered state. No input-to-output combinational path.
- start latency: start sampled at edge e. rk_valid=1 and rk=k_0 in the cycle after e.
- Throughput: one key per cycle with rk_ready held high. T keys take exactly T cycles.
- done is asserted in the cycle after the edge that accepts idx==T-1, for exactly one cycle. busy is 0 in that same cycle.
- A start asserted during the done cycle is accepted, because the FSM is already in IDLE. Back-to-back runs have a 1-cycle gap.
- zidx wraps 61→0. This path is exercised only when T>62.

## Test plan
- Paper vector: key = 0x0d0c0b0a0908_050403020100, start, rk_ready=1.
  - rk=0x050403020100 at idx 0, then 0x0d0c0b0a0908 at idx 1.
  - idx 2..51 match the C golden model.
  - done pulses exactly once, 52 cycles after the first rk_valid.
- Backpressure: same key, rk_ready toggled with a pseudo-random pattern.
  - rk and rk_idx stay stable while rk_valid=1 and rk_ready=0.
  - The accepted sequence is identical to the first test.
  - rk_last is high only for idx 51.
- Abort: start, accept 10 keys, then assert abort together with rk_ready=1 at idx 10.
  - Next cycle: IDLE, rk_valid=0, no done, rk=0, rk_idx=0.
  - A new start reproduces k_0 of the new key.
- Async reset mid-run: drop rst_n at idx 20 between clock edges.
  - All outputs go to 0 immediately.
  - After release, start with key=0 gives rk=0 at idx 0 and 0 at idx 1, then idx 2 = 0xFFFF_FFFF_FFFD (z2[0]=1).
- Start handling: pulse start at idx 5 with a different key; it is ignored and the sequence continues unchanged. Then assert start in the done cycle; the next cycle shows rk_valid=1, idx 0, new key.
- Wrap: T=100 build, rk_ready=1. Keys 62..99 match the golden model using z2 index (i mod 62).
